button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive differing synchronized samples required to change the debounced level; legal range 1..255.
REQ-002 Parameter REPEAT_DELAY, default 16: cycles from the press pulse to the first auto-repeat pulse; legal range 2..255.
REQ-003 Parameter REPEAT_PERIOD, default 4: cycles between subsequent auto-repeat pulses; legal range 1..255.
REQ-004 i_clk  input  1  rising-edge clock for all state.
REQ-005 i_reset_n  input  1  synchronous, active-low reset.
REQ-006 i_button  input  1  raw, asynchronous, bouncing push-button level; active high.
REQ-007 i_mode  input  1  output select: 0 = level mode, 1 = pulse mode.
REQ-008 i_repeat_en  input  1  enables auto-repeat pulses while the button is held.
REQ-009 o_level  output  1  debounced button level.
REQ-010 o_pulse  output  1  single-cycle strobe: press pulse and auto-repeat pulses.
REQ-011 o_en  output  1  count enable for the downstream 8-bit counter: o_pulse when i_mode=1, o_level when i_mode=0.

Function
REQ-012 i_button SHALL pass through a 2-flop synchronizer; only the second flop output (sync) is used by any other logic.
REQ-013 A debounce counter SHALL increment on each edge where sync != o_level, and SHALL clear on any edge where sync == o_level.
REQ-014 o_level SHALL toggle, and the debounce counter SHALL clear, on the DEBOUNCE_CYCLES-th consecutive edge with sync != o_level.
REQ-015 Latency: a clean input step SHALL appear on o_level on the (DEBOUNCE_CYCLES+2)-th rising edge after the step.
REQ-016 An input glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change o_level.
REQ-017 The pulse FSM SHALL have the states IDLE, DELAY and REPEAT, plus an 8-bit timer.
REQ-018 IDLE->DELAY on the edge where o_level goes 0->1: o_pulse=1 on that same edge, timer cleared to 0.
REQ-019 DELAY: the timer SHALL increment each cycle; on the edge where timer reaches REPEAT_DELAY-1 with i_repeat_en=1, the FSM SHALL assert o_pulse, clear the timer and enter REPEAT.
REQ-020 DELAY with i_repeat_en=0: the timer SHALL saturate at REPEAT_DELAY-1 and the FSM SHALL stay in DELAY with no pulse.
REQ-021 DELAY with i_repeat_en returning to 1 after saturation: a pulse SHALL occur on the next edge.
REQ-022 REPEAT: o_pulse SHALL assert for one cycle each REPEAT_PERIOD cycles (timer wraps at REPEAT_PERIOD-1).
REQ-023 REPEAT with i_repeat_en=0: the FSM SHALL return to DELAY with a saturated timer.
REQ-024 Any state: o_level going 1->0 SHALL force IDLE and clear the timer on that edge, with no pulse on the release edge.
REQ-025 Pulse spacing: o_pulse SHALL never be high on two consecutive cycles unless REPEAT_PERIOD=1.
REQ-026 Width rule: the timer and debounce counter are 8 bits wide and SHALL never wrap.
REQ-027 o_en SHALL be combinational from i_mode and registered o_pulse/o_level; i_mode may change at any time, and that change is glitch-free only with respect to registered sources.

Reset
REQ-028 With i_reset_n=0 at a rising edge, the synchronizer flops, o_level, o_pulse, the debounce counter and the timer SHALL all be 0, and the FSM SHALL be IDLE.
REQ-029 Consequently o_en SHALL be 0 the cycle after reset in either mode.
REQ-030 Reset asserted mid-press or mid-repeat SHALL abort immediately, with no pulse on the reset edge.
REQ-031 After reset release with the button held, a press SHALL be re-detected after DEBOUNCE_CYCLES+2 edges.

Verification
REQ-032 Defaults; i_button 0->1 held 40 cycles, i_repeat_en=0 -> o_level rises at edge 6, exactly one o_pulse at edge 6, none after.
REQ-033 Glitch: i_button high for 3 cycles, then low -> o_level and o_pulse stay 0 throughout.
REQ-034 Hold 40 cycles with i_repeat_en=1 -> pulses at edges 6, 22, 26, 30, 34, ... while held; none after release is debounced.
REQ-035 i_mode=0, hold 10 cycles -> o_en equals o_level (high from edge 6 until 6 edges after release); i_mode=1 -> o_en equals o_pulse.
REQ-036 Bounce pattern 1,0,1,0,1 each 1 cycle, then steady 1 -> single o_pulse, 6 edges after the steady level begins.
REQ-037 Reset asserted at edge 24 of a repeating hold -> all outputs 0 at edge 24; after release, the next pulse occurs 6 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, counting debouncer and a
// press / auto-repeat pulse FSM. o_en selects between the debounced level
// and the pulse train to drive a downstream counter enable.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_button,
  input  logic i_mode,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_pulse,
  output logic o_en
);

  // Terminal counts; compared with >= so an out-of-range value can never wrap.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] RD_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RP_LAST = 8'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic       sync_meta_q;
  logic       sync_q;
  logic [7:0] db_cnt_q;
  logic [7:0] db_cnt_d;
  logic       level_q;
  logic       level_d;
  logic       toggle_s;
  logic       rise_s;
  logic       fall_s;
  state_t     state_q;
  state_t     state_d;
  logic [7:0] timer_q;
  logic [7:0] timer_d;
  logic       pulse_q;
  logic       pulse_d;

  // Two-flop synchronizer; only sync_q is consumed downstream.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= i_button;
      sync_q      <= sync_meta_q;
    end
  end

  // Debounce next state: count disagreeing samples, flip level on the last one.
  always_comb begin
    db_cnt_d = 8'd0;
    level_d  = level_q;
    toggle_s = 1'b0;
    if (sync_q != level_q) begin
      if (db_cnt_q >= DB_LAST) begin
        toggle_s = 1'b1;
        level_d  = ~level_q;
        db_cnt_d = 8'd0;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end else begin
      db_cnt_d = 8'd0;
    end
  end

  // Level edges as seen on the edge where o_level itself changes.
  assign rise_s = toggle_s & ~level_q;
  assign fall_s = toggle_s & level_q;

  // Debounce state registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      db_cnt_q <= 8'd0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // Pulse FSM next state: press pulse, initial delay, then periodic repeats.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    if (fall_s) begin
      // Release wins over everything and never emits a pulse.
      state_d = ST_IDLE;
      timer_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            state_d = ST_DELAY;
            timer_d = 8'd0;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            timer_d = 8'd0;
          end
        end
        ST_DELAY: begin
          if (timer_q >= RD_LAST) begin
            if (i_repeat_en) begin
              state_d = ST_REPEAT;
              timer_d = 8'd0;
              pulse_d = 1'b1;
            end else begin
              // Hold saturated so re-enabling repeats fires on the next edge.
              timer_d = RD_LAST;
            end
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        ST_REPEAT: begin
          if (!i_repeat_en) begin
            state_d = ST_DELAY;
            timer_d = RD_LAST;
          end else if (timer_q >= RP_LAST) begin
            timer_d = 8'd0;
            pulse_d = 1'b1;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = 8'd0;
        end
      endcase
    end
  end

  // Pulse FSM state registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_level = level_q;
  assign o_pulse = pulse_q;
  // Mode mux over registered sources only.
  assign o_en    = i_mode ? pulse_q : level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus a
// randomized run against an edge-indexed behavioural model.
module tb_button_conditioner;

  localparam int D    = 4;
  localparam int RD   = 16;
  localparam int RP   = 4;
  localparam int MAXE = 8000;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_button = 1'b0;
  logic i_mode = 1'b0;
  logic i_repeat_en = 1'b0;
  logic o_level;
  logic o_pulse;
  logic o_en;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: history of what the DUT sampled at each edge.
  int edge_n = 0;
  bit btn_a [0:MAXE];
  bit rst_a [0:MAXE];
  bit m_level = 1'b0;
  bit m_pulse = 1'b0;
  bit m_en = 1'b0;
  int last_tog = 0;
  int next_allowed = 0;
  bit repeating = 1'b0;

  button_conditioner dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_button   (i_button),
    .i_mode     (i_mode),
    .i_repeat_en(i_repeat_en),
    .o_level    (o_level),
    .o_pulse    (o_pulse),
    .o_en       (o_en)
  );

  always #5 i_clk = ~i_clk;

  // Synchronized sample the debouncer looks at on edge n.
  function automatic bit s_at(int n);
    if (n < 2) return 1'b0;
    if (rst_a[n-1] || rst_a[n-2]) return 1'b0;
    return btn_a[n-2];
  endfunction

  // Drive one cycle, then advance the model by one edge.
  task automatic step(input bit b, input bit en, input bit mode, input bit rstn);
    bit prev;
    bit tog;
    i_button = b; i_repeat_en = en; i_mode = mode; i_reset_n = rstn;
    @(posedge i_clk); #1;
    edge_n++;
    btn_a[edge_n] = b;
    rst_a[edge_n] = ~rstn;
    prev = m_level;
    m_pulse = 1'b0;
    if (!rstn) begin
      m_level = 1'b0; last_tog = edge_n; repeating = 1'b0;
    end else begin
      // Level flips once D consecutive samples since the last flip disagree.
      tog = 1'b1;
      for (int k = 0; k < D; k++)
        if ((edge_n - k) <= last_tog || s_at(edge_n - k) == prev) tog = 1'b0;
      if (tog) begin m_level = ~prev; last_tog = edge_n; end
      if (tog && m_level) begin
        m_pulse = 1'b1; next_allowed = edge_n + RD; repeating = 1'b0;
      end else if (m_level) begin
        if (en) begin
          if (edge_n >= next_allowed) begin
            m_pulse = 1'b1; next_allowed = edge_n + RP; repeating = 1'b1;
          end
        end else if (repeating) begin
          repeating = 1'b0; next_allowed = edge_n + 1;
        end
      end
    end
    m_en = mode ? m_pulse : m_level;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, i[0], 1'b0);
      n_cmp++; if (o_level !== 1'b0) begin n_bad++; $display("FAIL reset_level: got %b expected 0", o_level); end
      n_cmp++; if (o_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0", o_pulse); end
      n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL reset_en mode%0d: got %b expected 0", i[0], o_en); end
    end
    flush(12);
  endtask

  task automatic test_press_no_repeat();
    int rise_at = -1; int fall_at = -1; int pcount = 0; int p_at = -1;
    for (int i = 1; i <= 52; i++) begin
      step(i <= 40, 1'b0, 1'b1, 1'b1);
      if (o_level === 1'b1 && rise_at < 0) rise_at = i;
      if (o_level === 1'b0 && rise_at > 0 && fall_at < 0) fall_at = i;
      if (o_pulse === 1'b1) begin pcount++; p_at = i; end
    end
    n_cmp++; if (rise_at !== 6) begin n_bad++; $display("FAIL norep_rise: got %0d expected 6", rise_at); end
    n_cmp++; if (fall_at !== 46) begin n_bad++; $display("FAIL norep_fall: got %0d expected 46", fall_at); end
    n_cmp++; if (pcount !== 1) begin n_bad++; $display("FAIL norep_pcount: got %0d expected 1", pcount); end
    n_cmp++; if (p_at !== 6) begin n_bad++; $display("FAIL norep_pedge: got %0d expected 6", p_at); end
    flush(4);
  endtask

  task automatic test_glitch();
    int hi = 0;
    for (int i = 1; i <= 15; i++) begin
      step(i <= 3, 1'b1, 1'b1, 1'b1);
      if (o_level !== 1'b0 || o_pulse !== 1'b0) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL glitch: got %0d high cycles expected 0", hi); end
    flush(4);
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL %s_count: got %0d pulses expected %0d", name, got.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < got.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin n_bad++; $display("FAIL %s_pulse%0d: got edge %0d expected %0d", name, k, got[k], exp[k]); end
    end
  endtask

  task automatic test_repeat();
    int got[$];
    int exp[$] = '{6, 22, 26, 30, 34, 38, 42};
    for (int i = 1; i <= 52; i++) begin
      step(i <= 40, 1'b1, 1'b1, 1'b1);
      if (o_pulse === 1'b1) got.push_back(i);
    end
    check_list("repeat", got, exp);
    flush(4);
  endtask

  task automatic test_en_toggle();
    int got[$];
    int exp[$] = '{6, 31, 35, 39, 42, 46};
    for (int i = 1; i <= 56; i++) begin
      step(i <= 44, (i >= 31 && i <= 39) || i >= 42, 1'b1, 1'b1);
      if (o_pulse === 1'b1) got.push_back(i);
    end
    check_list("entoggle", got, exp);
    flush(4);
  endtask

  task automatic test_level_mode();
    int hi = 0; int first = -1; int phi = 0; int pfirst = -1;
    for (int i = 1; i <= 24; i++) begin
      step(i <= 10, 1'b0, 1'b0, 1'b1);
      if (o_en === 1'b1) begin hi++; if (first < 0) first = i; end
    end
    n_cmp++; if (hi !== 10) begin n_bad++; $display("FAIL lvlmode_count: got %0d expected 10", hi); end
    n_cmp++; if (first !== 6) begin n_bad++; $display("FAIL lvlmode_first: got %0d expected 6", first); end
    for (int i = 1; i <= 24; i++) begin
      step(i <= 10, 1'b1, 1'b1, 1'b1);
      if (o_en === 1'b1) begin phi++; if (pfirst < 0) pfirst = i; end
    end
    n_cmp++; if (phi !== 1) begin n_bad++; $display("FAIL pulsemode_count: got %0d expected 1", phi); end
    n_cmp++; if (pfirst !== 6) begin n_bad++; $display("FAIL pulsemode_first: got %0d expected 6", pfirst); end
  endtask

  task automatic test_bounce();
    int got[$];
    int exp[$] = '{10};
    bit pat [1:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= 40; i++) begin
      step((i <= 5) ? pat[i] : (i <= 28), 1'b0, 1'b1, 1'b1);
      if (o_pulse === 1'b1) got.push_back(i);
    end
    check_list("bounce", got, exp);
  endtask

  task automatic test_reset_mid_repeat();
    int got[$];
    int exp[$] = '{6, 22, 30, 46, 50, 54};
    for (int i = 1; i <= 62; i++) begin
      step(i <= 50, 1'b1, 1'b1, i != 24);
      if (o_pulse === 1'b1) got.push_back(i);
      if (i == 24) begin
        n_cmp++;
        if (o_level !== 1'b0 || o_pulse !== 1'b0 || o_en !== 1'b0) begin
          n_bad++; $display("FAIL midrst_outputs: got %b%b%b expected 000", o_level, o_pulse, o_en);
        end
      end
    end
    check_list("midrst", got, exp);
    flush(4);
  endtask

  task automatic test_random();
    bit b = 1'b0; bit en = 1'b0; bit md; bit rstn; bit prev_p = 1'b0; int run = 1;
    for (int i = 0; i < 2500; i++) begin
      run--;
      if (run <= 0) begin
        b = ~b;
        run = b ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 20));
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      md = 1'($urandom_range(0, 1));
      rstn = ($urandom_range(0, 299) != 0);
      step(b, en, md, rstn);
      n_cmp++; if (o_level !== m_level) begin n_bad++; $display("FAIL rand_level edge %0d: got %b expected %b", edge_n, o_level, m_level); end
      n_cmp++; if (o_pulse !== m_pulse) begin n_bad++; $display("FAIL rand_pulse edge %0d: got %b expected %b", edge_n, o_pulse, m_pulse); end
      n_cmp++; if (o_en !== m_en) begin n_bad++; $display("FAIL rand_en edge %0d: got %b expected %b", edge_n, o_en, m_en); end
      n_cmp++; if (o_pulse === 1'b1 && prev_p) begin n_bad++; $display("FAIL rand_spacing edge %0d: got back-to-back pulses expected gap", edge_n); end
      prev_p = o_pulse;
    end
  endtask

  initial begin
    test_reset();
    test_press_no_repeat();
    test_glitch();
    test_repeat();
    test_en_toggle();
    test_level_mode();
    test_bounce();
    test_reset_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
